axi_read_arbiter: RTL and testbench

//  Shares the two AXI read slaves (S0 = instruction SRAM, S1 = data SRAM) between
//  two read masters: M0 = instruction fetch, M1 = data load.

---
 rtl/axi_read_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Two-master / two-slave AXI read arbiter with address decode and an internal DECERR slave.
// Define AXI_RR_ARB_EN for round-robin arbitration; otherwise M1 has fixed priority over M0.
module axi_read_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned IDS_W  = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // master 0 (instruction fetch)
    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [LEN_W-1:0]  ARLEN_M0,
    input  logic [2:0]        ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,
    output logic [ID_W-1:0]   RID_M0,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [1:0]        RRESP_M0,
    output logic              RLAST_M0,
    output logic              RVALID_M0,
    input  logic              RREADY_M0,
    // master 1 (data load)
    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [LEN_W-1:0]  ARLEN_M1,
    input  logic [2:0]        ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,
    output logic [ID_W-1:0]   RID_M1,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [1:0]        RRESP_M1,
    output logic              RLAST_M1,
    output logic              RVALID_M1,
    input  logic              RREADY_M1,
    // slave 0 (instruction SRAM)
    output logic [IDS_W-1:0]  ARID_S0,
    output logic [ADDR_W-1:0] ARADDR_S0,
    output logic [LEN_W-1:0]  ARLEN_S0,
    output logic [2:0]        ARSIZE_S0,
    output logic [1:0]        ARBURST_S0,
    output logic              ARVALID_S0,
    input  logic              ARREADY_S0,
    input  logic [IDS_W-1:0]  RID_S0,
    input  logic [DATA_W-1:0] RDATA_S0,
    input  logic [1:0]        RRESP_S0,
    input  logic              RLAST_S0,
    input  logic              RVALID_S0,
    output logic              RREADY_S0,
    // slave 1 (data SRAM)
    output logic [IDS_W-1:0]  ARID_S1,
    output logic [ADDR_W-1:0] ARADDR_S1,
    output logic [LEN_W-1:0]  ARLEN_S1,
    output logic [2:0]        ARSIZE_S1,
    output logic [1:0]        ARBURST_S1,
    output logic              ARVALID_S1,
    input  logic              ARREADY_S1,
    input  logic [IDS_W-1:0]  RID_S1,
    input  logic [DATA_W-1:0] RDATA_S1,
    input  logic [1:0]        RRESP_S1,
    input  logic              RLAST_S1,
    input  logic              RVALID_S1,
    output logic              RREADY_S1
);

    localparam int unsigned TagW = IDS_W - ID_W;
    localparam logic [TagW-1:0] TagM0 = TagW'(1);
    localparam logic [TagW-1:0] TagM1 = TagW'(2);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;
    typedef enum logic [1:0] {TgtS0, TgtS1, TgtDef} tgt_e;

    function automatic tgt_e decode(input logic [ADDR_W-1:0] addr);
        unique case (addr[ADDR_W-1 -: 16])
            16'h0000: decode = TgtS0;
            16'h0001: decode = TgtS1;
            default:  decode = TgtDef;
        endcase
    endfunction

    state_e state_q, state_d;
    tgt_e   tgt_q;
    logic   grant_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [LEN_W-1:0]  beat_q, beat_d;

    logic req_any, gnt_sel, ar_load, ar_done;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [2:0]        sel_size;
    logic [1:0]        sel_burst;
    tgt_e              sel_tgt;

    logic              r_valid, r_last, r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic [ID_W-1:0]   r_id;

    // Upper RID bits carry our own master tag; routing uses grant_q instead.
    logic unused_rid_tag;
    assign unused_rid_tag = ^{RID_S0[IDS_W-1:ID_W], RID_S1[IDS_W-1:ID_W]};

    assign req_any = ARVALID_M0 | ARVALID_M1;
    assign ar_load = (state_q == StIdle) && req_any;

`ifdef AXI_RR_ARB_EN
    logic ptr_q;  // master favoured on a tie; reset favours M0
    assign gnt_sel = (ARVALID_M0 && ARVALID_M1) ? ptr_q : ARVALID_M1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_q <= 1'b0;
        end else if (ar_load) begin
            ptr_q <= ~gnt_sel;
        end
    end
`else
    assign gnt_sel = ARVALID_M1;
`endif

    assign sel_id    = gnt_sel ? ARID_M1    : ARID_M0;
    assign sel_addr  = gnt_sel ? ARADDR_M1  : ARADDR_M0;
    assign sel_len   = gnt_sel ? ARLEN_M1   : ARLEN_M0;
    assign sel_size  = gnt_sel ? ARSIZE_M1  : ARSIZE_M0;
    assign sel_burst = gnt_sel ? ARBURST_M1 : ARBURST_M0;
    assign sel_tgt   = decode(sel_addr);

    // Gated by reset so every output reads 0 while ARESETn is low.
    assign ARREADY_M0 = ARESETn && ar_load && !gnt_sel;
    assign ARREADY_M1 = ARESETn && ar_load && gnt_sel;

    assign ar_done = (tgt_q == TgtS0 && ARREADY_S0) || (tgt_q == TgtS1 && ARREADY_S1);

    always_comb begin
        r_valid = 1'b0;
        r_data  = '0;
        r_resp  = 2'b00;
        r_last  = 1'b0;
        r_id    = '0;
        if (state_q == StData) begin
            unique case (tgt_q)
                TgtS0: begin
                    r_valid = RVALID_S0;
                    r_data  = RDATA_S0;
                    r_resp  = RRESP_S0;
                    r_last  = RLAST_S0;
                    r_id    = RID_S0[ID_W-1:0];
                end
                TgtS1: begin
                    r_valid = RVALID_S1;
                    r_data  = RDATA_S1;
                    r_resp  = RRESP_S1;
                    r_last  = RLAST_S1;
                    r_id    = RID_S1[ID_W-1:0];
                end
                default: begin
                    r_valid = 1'b1;
                    r_resp  = 2'b11;
                    r_last  = (beat_q == len_q);
                    r_id    = id_q;
                end
            endcase
        end
    end

    assign r_ready = grant_q ? RREADY_M1 : RREADY_M0;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d = (sel_tgt == TgtDef) ? StData : StAddr;
                    beat_d  = '0;
                end
            end
            StAddr: begin
                if (ar_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tgt_q == TgtDef && r_ready) begin
                    beat_d = beat_q + 1'b1;
                end
                if (r_valid && r_ready && r_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
            tgt_q   <= TgtS0;
            grant_q <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (ar_load) begin
                tgt_q   <= sel_tgt;
                grant_q <= gnt_sel;
                id_q    <= sel_id;
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                size_q  <= sel_size;
                burst_q <= sel_burst;
            end
        end
    end

    always_comb begin
        ARVALID_S0 = (state_q == StAddr) && (tgt_q == TgtS0);
        ARVALID_S1 = (state_q == StAddr) && (tgt_q == TgtS1);
        ARID_S0    = ARVALID_S0 ? {grant_q ? TagM1 : TagM0, id_q} : '0;
        ARADDR_S0  = ARVALID_S0 ? addr_q  : '0;
        ARLEN_S0   = ARVALID_S0 ? len_q   : '0;
        ARSIZE_S0  = ARVALID_S0 ? size_q  : '0;
        ARBURST_S0 = ARVALID_S0 ? burst_q : '0;
        ARID_S1    = ARVALID_S1 ? {grant_q ? TagM1 : TagM0, id_q} : '0;
        ARADDR_S1  = ARVALID_S1 ? addr_q  : '0;
        ARLEN_S1   = ARVALID_S1 ? len_q   : '0;
        ARSIZE_S1  = ARVALID_S1 ? size_q  : '0;
        ARBURST_S1 = ARVALID_S1 ? burst_q : '0;
        RREADY_S0  = (state_q == StData) && (tgt_q == TgtS0) && r_ready;
        RREADY_S1  = (state_q == StData) && (tgt_q == TgtS1) && r_ready;

        RVALID_M0 = r_valid && !grant_q;
        RDATA_M0  = grant_q ? '0 : r_data;
        RRESP_M0  = grant_q ? '0 : r_resp;
        RLAST_M0  = r_last && !grant_q;
        RID_M0    = grant_q ? '0 : r_id;
        RVALID_M1 = r_valid && grant_q;
        RDATA_M1  = grant_q ? r_data : '0;
        RRESP_M1  = grant_q ? r_resp : '0;
        RLAST_M1  = r_last && grant_q;
        RID_M1    = grant_q ? r_id : '0;
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter: behavioural masters/slaves plus a transaction-level
// model of arbitration, decode and burst routing.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0, ARESETn = 1'b0;
    logic [3:0]  arid_m0, arid_m1, arlen_m0, arlen_m1;
    logic [31:0] araddr_m0, araddr_m1;
    logic [2:0]  arsize_m0, arsize_m1;
    logic [1:0]  arburst_m0, arburst_m1;
    logic        arvalid_m0, arvalid_m1, arready_m0, arready_m1;
    logic [3:0]  rid_m0, rid_m1;
    logic [31:0] rdata_m0, rdata_m1;
    logic [1:0]  rresp_m0, rresp_m1;
    logic        rlast_m0, rlast_m1, rvalid_m0, rvalid_m1, rready_m0, rready_m1;
    logic [7:0]  arid_s0, arid_s1, rid_s0, rid_s1;
    logic [31:0] araddr_s0, araddr_s1, rdata_s0, rdata_s1;
    logic [3:0]  arlen_s0, arlen_s1;
    logic [2:0]  arsize_s0, arsize_s1;
    logic [1:0]  arburst_s0, arburst_s1, rresp_s0, rresp_s1;
    logic        arvalid_s0, arvalid_s1, arready_s0, arready_s1;
    logic        rlast_s0, rlast_s1, rvalid_s0, rvalid_s1, rready_s0, rready_s1;

    always #5 ACLK = ~ACLK;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(arid_m0), .ARADDR_M0(araddr_m0), .ARLEN_M0(arlen_m0), .ARSIZE_M0(arsize_m0),
        .ARBURST_M0(arburst_m0), .ARVALID_M0(arvalid_m0), .ARREADY_M0(arready_m0),
        .RID_M0(rid_m0), .RDATA_M0(rdata_m0), .RRESP_M0(rresp_m0), .RLAST_M0(rlast_m0),
        .RVALID_M0(rvalid_m0), .RREADY_M0(rready_m0),
        .ARID_M1(arid_m1), .ARADDR_M1(araddr_m1), .ARLEN_M1(arlen_m1), .ARSIZE_M1(arsize_m1),
        .ARBURST_M1(arburst_m1), .ARVALID_M1(arvalid_m1), .ARREADY_M1(arready_m1),
        .RID_M1(rid_m1), .RDATA_M1(rdata_m1), .RRESP_M1(rresp_m1), .RLAST_M1(rlast_m1),
        .RVALID_M1(rvalid_m1), .RREADY_M1(rready_m1),
        .ARID_S0(arid_s0), .ARADDR_S0(araddr_s0), .ARLEN_S0(arlen_s0), .ARSIZE_S0(arsize_s0),
        .ARBURST_S0(arburst_s0), .ARVALID_S0(arvalid_s0), .ARREADY_S0(arready_s0),
        .RID_S0(rid_s0), .RDATA_S0(rdata_s0), .RRESP_S0(rresp_s0), .RLAST_S0(rlast_s0),
        .RVALID_S0(rvalid_s0), .RREADY_S0(rready_s0),
        .ARID_S1(arid_s1), .ARADDR_S1(araddr_s1), .ARLEN_S1(arlen_s1), .ARSIZE_S1(arsize_s1),
        .ARBURST_S1(arburst_s1), .ARVALID_S1(arvalid_s1), .ARREADY_S1(arready_s1),
        .RID_S1(rid_s1), .RDATA_S1(rdata_s1), .RRESP_S1(rresp_s1), .RLAST_S1(rlast_s1),
        .RVALID_S1(rvalid_s1), .RREADY_S1(rready_s1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural master request state
    bit          m_pend [2];
    logic [3:0]  m_id   [2];
    logic [31:0] m_addr [2];
    logic [3:0]  m_len  [2];
    logic [2:0]  m_size [2];
    logic [1:0]  m_burst[2];
    bit          m_rdy  [2];
    // Transaction-level arbiter model
    bit          busy, def_live, rand_on;
    bit          ar_wait[2];
    int          own, tgt, beat, last_g, completed;
    logic [31:0] b_addr;
    logic [3:0]  b_len, b_id;
    logic [2:0]  b_size;
    logic [1:0]  b_burst;
    // Behavioural slaves
    bit          s_act[2], s_ardy[2];
    logic [7:0]  s_id[2];
    logic [31:0] s_addr[2];
    logic [3:0]  s_len[2];
    int          s_beat[2], s_dly[2];

    function automatic int decode(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 0;
        if (a[31:16] == 16'h0001) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] sdata(input int k, input logic [31:0] a, input int b);
        return 32'hDEAD_BEEF ^ a ^ (32'(b) << 12) ^ ((k == 1) ? 32'h1234_0000 : 32'h0);
    endfunction

    task automatic set_req(input int m, input logic [31:0] a, input logic [3:0] l,
                           input logic [3:0] id);
        m_pend[m] = 1'b1;
        m_addr[m] = a;
        m_len[m] = l;
        m_id[m] = id;
        m_size[m] = 3'($urandom_range(0, 7));
        m_burst[m] = 2'($urandom_range(0, 2));
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        logic [15:0] hi;
        r = $urandom_range(0, 2);
        hi = (r == 0) ? 16'h0000 : (r == 1) ? 16'h0001 : 16'($urandom_range(2, 65535));
        return {hi, 16'($urandom)};
    endfunction

    task automatic clear_model();
        busy = 0; def_live = 0; last_g = 1;
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_rdy[i] = 0; ar_wait[i] = 0; s_act[i] = 0; s_ardy[i] = 0;
        end
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (rand_on && !m_pend[m] && $urandom_range(0, 3) == 0)
                set_req(m, rand_addr(), 4'($urandom_range(0, 5)), 4'($urandom));
            m_rdy[m] = ($urandom_range(0, 3) != 0);
            s_ardy[m] = ($urandom_range(0, 1) != 0);
        end
        arvalid_m0 = m_pend[0]; araddr_m0 = m_addr[0]; arlen_m0 = m_len[0]; arid_m0 = m_id[0];
        arsize_m0 = m_size[0]; arburst_m0 = m_burst[0]; rready_m0 = m_rdy[0];
        arvalid_m1 = m_pend[1]; araddr_m1 = m_addr[1]; arlen_m1 = m_len[1]; arid_m1 = m_id[1];
        arsize_m1 = m_size[1]; arburst_m1 = m_burst[1]; rready_m1 = m_rdy[1];
        arready_s0 = s_ardy[0]; arready_s1 = s_ardy[1];
        rvalid_s0 = s_act[0] && s_dly[0] == 0; rid_s0 = s_id[0]; rresp_s0 = 2'b00;
        rdata_s0 = sdata(0, s_addr[0], s_beat[0]); rlast_s0 = (s_beat[0] == int'(s_len[0]));
        rvalid_s1 = s_act[1] && s_dly[1] == 0; rid_s1 = s_id[1]; rresp_s1 = 2'b00;
        rdata_s1 = sdata(1, s_addr[1], s_beat[1]); rlast_s1 = (s_beat[1] == int'(s_len[1]));
    endtask

    task automatic sample();
        logic [1:0] exp_rdy, rdy_act, rv_act, arv_act, exp_rrs;
        bit rv_exp, was_busy;
        int g;
        logic [7:0]  a_id  [2];
        logic [31:0] a_addr[2];
        logic [3:0]  a_len [2];
        logic [4:0]  a_sb  [2];
        bit          s_rv  [2];
        a_id = '{arid_s0, arid_s1};
        a_addr = '{araddr_s0, araddr_s1};
        a_len = '{arlen_s0, arlen_s1};
        a_sb = '{{arsize_s0, arburst_s0}, {arsize_s1, arburst_s1}};
        s_rv = '{rvalid_s0, rvalid_s1};
        rdy_act = {arready_m1, arready_m0};
        rv_act = {rvalid_m1, rvalid_m0};
        arv_act = {arvalid_s1, arvalid_s0};

        exp_rdy = 2'b00;
        if (!busy && (m_pend[0] || m_pend[1])) begin
            if (m_pend[0] && m_pend[1]) begin
`ifdef AXI_RR_ARB_EN
                g = (last_g == 0) ? 1 : 0;
`else
                g = 1;
`endif
            end else g = m_pend[1] ? 1 : 0;
            exp_rdy[g] = 1'b1;
        end
        check("arready_m", rdy_act, exp_rdy);

        check("arvalid_s", arv_act, {ar_wait[1], ar_wait[0]});
        for (int k = 0; k < 2; k++) if (ar_wait[k] && arv_act[k]) begin
            check("arid_s", a_id[k], {4'(own + 1), b_id});
            check("araddr_s", a_addr[k], b_addr);
            check("arlen_s", a_len[k], b_len);
            check("arsize_burst_s", a_sb[k], {b_size, b_burst});
        end

        rv_exp = busy && ((tgt == 2) ? def_live : (s_act[tgt] && s_dly[tgt] == 0));
        check("rvalid_m", rv_act, rv_exp ? 2'(1 << own) : 2'b00);
        if (rv_exp) begin
            check("rdata_m", own ? rdata_m1 : rdata_m0, (tgt == 2) ? 32'h0 : sdata(tgt, b_addr, beat));
            check("rresp_m", own ? rresp_m1 : rresp_m0, (tgt == 2) ? 2'b11 : 2'b00);
            check("rlast_m", own ? rlast_m1 : rlast_m0, beat == int'(b_len));
            check("rid_m", own ? rid_m1 : rid_m0, b_id);
        end
        exp_rrs = 2'b00;
        if (busy && tgt < 2 && s_act[tgt]) exp_rrs[tgt] = m_rdy[own];
        check("rready_s", {rready_s1, rready_s0}, exp_rrs);

        // advance the model on the handshakes that happen at the coming edge
        was_busy = busy;
        if (rv_exp && rv_act[own] && m_rdy[own]) begin
            if (beat == int'(b_len)) begin
                busy = 0; def_live = 0; completed++;
            end
            beat++;
        end
        for (int k = 0; k < 2; k++) begin
            if (s_act[k] && s_rv[k] && (k ? rready_s1 : rready_s0)) begin
                if (s_beat[k] == int'(s_len[k])) s_act[k] = 0;
                s_beat[k]++;
                s_dly[k] = $urandom_range(0, 2);
            end else if (s_act[k] && s_dly[k] > 0) s_dly[k]--;
            if (ar_wait[k] && arv_act[k] && s_ardy[k]) begin
                ar_wait[k] = 0; s_act[k] = 1; s_beat[k] = 0; s_dly[k] = $urandom_range(0, 2);
                s_id[k] = {4'(own + 1), b_id}; s_addr[k] = b_addr; s_len[k] = b_len;
            end
        end
        for (int m = 0; m < 2; m++) if (m_pend[m] && rdy_act[m]) begin
            m_pend[m] = 0;
            if (!was_busy && !busy) begin
                busy = 1; own = m; last_g = m; beat = 0;
                b_addr = m_addr[m]; b_len = m_len[m]; b_id = m_id[m];
                b_size = m_size[m]; b_burst = m_burst[m];
                tgt = decode(b_addr);
                if (tgt == 2) def_live = 1; else ar_wait[tgt] = 1;
            end
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        drive();
        #1;
        sample();
    endtask

    task automatic run_quiet(input int maxc);
        int c = 0;
        while ((busy || m_pend[0] || m_pend[1]) && c < maxc) begin
            step();
            c++;
        end
        check("quiet_timeout", {busy, m_pend[0], m_pend[1]}, 3'b000);
    endtask

    task automatic run_random(input int ntx, input int maxc);
        int c = 0;
        completed = 0;
        rand_on = 1;
        while (completed < ntx && c < maxc) begin
            step();
            c++;
        end
        rand_on = 0;
        check("txn_count", completed >= ntx, 1'b1);
        run_quiet(2000);
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < 2; i++) m_rdy[i] = 0;
        arvalid_m0 = 0; arvalid_m1 = 0; rready_m0 = 0; rready_m1 = 0;
        arready_s0 = 0; arready_s1 = 0; rvalid_s0 = 0; rvalid_s1 = 0;
        rlast_s0 = 0; rlast_s1 = 0;
    endtask

    initial begin
        int c;
        clear_model();
        rand_on = 0;
        completed = 0;
        for (int i = 0; i < 2; i++) begin
            m_id[i] = 0; m_addr[i] = 0; m_len[i] = 0; m_size[i] = 0; m_burst[i] = 0;
            s_id[i] = 0; s_addr[i] = 0; s_len[i] = 0; s_beat[i] = 0; s_dly[i] = 0;
        end
        drive();
        zero_inputs();
        #2;
        check("reset_outputs", {arready_m0, arready_m1, rvalid_m0, rvalid_m1,
                                arvalid_s0, arvalid_s1, rready_s0, rready_s1}, 8'h00);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;

        // single-beat fetch from S0, multi-beat load from S1, DECERR burst, then two ties
        set_req(0, 32'h0000_0040, 4'd0, 4'd3);
        run_quiet(200);
        set_req(1, 32'h0001_0000, 4'd3, 4'd5);
        run_quiet(200);
        set_req(1, 32'h0005_0000, 4'd2, 4'd9);
        run_quiet(200);
        for (int r = 0; r < 2; r++) begin
            set_req(0, 32'h0000_0100, 4'd1, 4'd1);
            set_req(1, 32'h0001_0200, 4'd1, 4'd2);
            run_quiet(300);
        end

        run_random(60, 20000);

        // abort a multi-beat slave burst part way through with an async reset
        rand_on = 1;
        c = 0;
        while (!(busy && tgt < 2 && beat >= 1 && b_len >= 2) && c < 5000) begin
            step();
            c++;
        end
        rand_on = 0;
        check("midburst_found", busy && tgt < 2 && beat >= 1, 1'b1);
        #2;
        ARESETn = 1'b0;
        #1;
        check("async_reset_valids", {arready_m0, arready_m1, rvalid_m0, rvalid_m1,
                                     arvalid_s0, arvalid_s1, rready_s0, rready_s1}, 8'h00);
        clear_model();
        zero_inputs();
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        set_req(0, 32'h0000_0080, 4'd3, 4'd7);
        run_quiet(300);

        run_random(60, 20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
